// File: rtl/bcd_pkg.sv
// Shared state encoding, BCD constants and a digit-validity helper for the
// digit-serial BCD subtractor.
package bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [4:0] BCD_RADIX = 5'd10;

  function automatic logic bcd_valid(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/BCD_to_9Comp.sv
// Nine's complement of one BCD digit; e_o flags a non-decimal input code.
module BCD_to_9Comp
  import bcd_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [3:0] comp_o,
  output logic       e_o
);

  assign comp_o = BCD_MAX - bcd_i;
  assign e_o    = (bcd_i > BCD_MAX);

endmodule

// File: rtl/bcd_digit_add.sv
// One BCD digit adder with carry: x + y + cin, folded back into 0..9 with
// a decimal carry out.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] x_i,
  input  logic [3:0] y_i,
  input  logic       cin_i,
  output logic [3:0] digit_o,
  output logic       cout_o
);

  logic [4:0] sum_s;

  always_comb begin
    sum_s = {1'b0, x_i} + {1'b0, y_i} + {4'b0000, cin_i};
    if (sum_s >= BCD_RADIX) begin
      digit_o = 4'(sum_s - BCD_RADIX);
      cout_o  = 1'b1;
    end else begin
      digit_o = sum_s[3:0];
      cout_o  = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_sub_seq.sv
// Digit-serial |a - b| over DIGITS BCD digits: a subtract pass via nine's
// complement, then a recomplement pass only when the result went negative.
module bcd_sub_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   diff,
  output logic                  neg,
  output logic                  err
);

  localparam int              IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  cy_q, cy_d;
  logic [4*DIGITS-1:0]   a_q, a_d;
  logic [4*DIGITS-1:0]   b_q, b_d;
  logic [4*DIGITS-1:0]   diff_q, diff_d;
  logic                  neg_q, neg_d;
  logic                  err_q, err_d;

  logic                  bad_digit_s;
  logic [3:0]            conv_in_s;
  logic [3:0]            conv_out_s;
  logic                  conv_e_s;
  logic [3:0]            add_x_s;
  logic [3:0]            add_y_s;
  logic [3:0]            add_digit_s;
  logic                  add_cout_s;

  // The converter is shared: b digits while subtracting, result digits while fixing.
  always_comb begin
    conv_in_s = 4'd0;
    case (state_q)
      S_SUB:   conv_in_s = b_q[{idx_q, 2'b00} +: 4];
      S_FIX:   conv_in_s = diff_q[{idx_q, 2'b00} +: 4];
      default: conv_in_s = 4'd0;
    endcase
  end

  BCD_to_9Comp u_comp (
    .bcd_i  (conv_in_s),
    .comp_o (conv_out_s),
    .e_o    (conv_e_s)
  );

  assign add_x_s = (state_q == S_SUB) ? a_q[{idx_q, 2'b00} +: 4] : conv_out_s;
  assign add_y_s = (state_q == S_SUB) ? conv_out_s : 4'd0;

  bcd_digit_add u_add (
    .x_i     (add_x_s),
    .y_i     (add_y_s),
    .cin_i   (cy_q),
    .digit_o (add_digit_s),
    .cout_o  (add_cout_s)
  );

  always_comb begin
    bad_digit_s = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_valid(a[4*i +: 4]) || !bcd_valid(b[4*i +: 4])) begin
        bad_digit_s = 1'b1;
      end else begin
        bad_digit_s = bad_digit_s;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    neg_d   = neg_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d   = a;
          b_d   = b;
          neg_d = 1'b0;
          if (bad_digit_s) begin
            err_d   = 1'b1;
            diff_d  = '0;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            idx_d   = '0;
            cy_d    = 1'b1;
            state_d = S_SUB;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SUB: begin
        diff_d[{idx_q, 2'b00} +: 4] = add_digit_s;
        cy_d  = add_cout_s;
        idx_d = idx_q + IDX_ONE;
        if (idx_q == LAST_IDX) begin
          // A final carry means a >= b; no carry leaves the 10's complement of b - a.
          if (add_cout_s) begin
            neg_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            neg_d   = 1'b1;
            idx_d   = '0;
            cy_d    = 1'b1;
            state_d = S_FIX;
          end
        end else begin
          state_d = S_SUB;
        end
      end
      S_FIX: begin
        diff_d[{idx_q, 2'b00} +: 4] = add_digit_s;
        cy_d  = add_cout_s;
        idx_d = idx_q + IDX_ONE;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FIX;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q == S_SUB) || (state_q == S_FIX);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign neg  = neg_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_sub_seq.sv
// Scoreboard bench for bcd_sub_seq: expected results are queued at start and
// compared whenever done pulses; latency and busy length are checked per op.
module tb_bcd_sub_seq;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  typedef struct {
    logic [W-1:0] diff;
    logic         neg;
    logic         err;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         neg;
  logic         err;

  int   checks;
  int   errors;
  exp_t sb_q[$];

  bcd_sub_seq #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .neg   (neg),
    .err   (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] r = '0;
    int           m = n;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [W-1:0] v);
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_val("diff", 32'(diff), 32'(e.diff));
        check_val("neg", 32'(neg), 32'(e.neg));
        check_val("err", 32'(err), 32'(e.err));
      end
    end
  end

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit noisy);
    exp_t e;
    int   ia, ib, lat, nbusy, exp_lat, exp_busy;
    e.err = has_bad(av) || has_bad(bv);
    if (e.err) begin
      e.diff = '0;
      e.neg  = 1'b0;
    end else begin
      ia     = bcd2int(av);
      ib     = bcd2int(bv);
      e.neg  = (ia < ib);
      e.diff = int2bcd(e.neg ? ib - ia : ia - ib);
    end
    exp_lat  = e.err ? 1 : (e.neg ? 2 * DIGITS + 1 : DIGITS + 1);
    exp_busy = e.err ? 0 : (e.neg ? 2 * DIGITS : DIGITS);
    sb_q.push_back(e);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    lat   = 0;
    nbusy = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        lat = c;
        break;
      end
      if (noisy) begin
        a     = av ^ 16'h1111;
        b     = 16'h0000;
        start = (c == 2 || c == 5) ? 1'b1 : 1'b0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_val("latency", 32'(lat), 32'(exp_lat));
    check_val("busy_cycles", 32'(nbusy), 32'(exp_busy));
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_diff", 32'(diff), 32'd0);
    check_val("rst_neg", 32'(neg), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op(16'h0500, 16'h0123, 1'b0);
    run_op(16'h0005, 16'h0012, 1'b0);
    run_op(16'h1234, 16'h1234, 1'b0);
    run_op(16'h0000, 16'h9999, 1'b0);
    run_op(16'h0000, 16'h00A0, 1'b0);
    run_op(16'h0500, 16'h0123, 1'b0);
    run_op(16'h0005, 16'h0012, 1'b1);
    run_op(16'h0987, 16'h0042, 1'b1);
    run_op(16'h9999, 16'h0001, 1'b0);

    // Abort an op in its recomplement pass with an asynchronous reset.
    @(negedge clk);
    a     = 16'h0000;
    b     = 16'h9999;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_val("mid_fix_busy", 32'(busy), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    check_val("abort_diff", 32'(diff), 32'd0);
    check_val("abort_neg", 32'(neg), 32'd0);
    check_val("abort_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    run_op(16'h0005, 16'h0012, 1'b0);

    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
